load_store_unit: RTL
====================

# load_store_unit

Data-memory responder for the RV32I pipeline. Consumes memory-stage control and data (`regwriteM`, `resultsrcM`, `memwriteM`, `aluresultM`, `Rd2M`, `RdM`), services word loads and stores over a request/grant/response memory port, stalls the pipeline while an access is outstanding, and registers the writeback-stage result. Non-memory instructions pass through to writeback with one cycle of latency.

## Interface
- `DPW`, 32, data and address width; use `rv32i_pkg::DPW`.
- `TIMEOUT_CYC`, 16, watchdog limit in cycles, ≥2. Used only with `LSU_TIMEOUT_EN`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `arst_n`  in  1  reset; synchronous, active-low.
- `regwriteM`, `resultsrcM`, `memwriteM`  in  1 each  M-stage controls. `resultsrcM`=1 selects a load.
- `aluresultM`  in  DPW  byte address for memory ops, or the result for ALU ops.
- `Rd2M`  in  DPW  store data.
- `RdM`  in  5  destination register.
- `mem_req_o`  out  1  memory request valid.
- `mem_we_o`  out  1  1 = store, 0 = load.
- `mem_addr_o`  out  DPW  word-aligned address; bits [1:0] are forced to 0.
- `mem_wdata_o`  out  DPW  store data.
- `mem_gnt_i`  in  1  request accepted this cycle.
- `mem_rvalid_i`  in  1  load data valid.
- `mem_rdata_i`  in  DPW  load data.
- `stall_o`  out  1  freeze PC, F/D/E and M registers; combinational.
- `regwriteW`  out  1  writeback enable.
- `RdW`  out  5  writeback register.
- `resultW`  out  DPW  writeback data.
- `lsu_err_o`  out  1  one-cycle timeout pulse.

## Operation
- An access is `acc` = `memwriteM | resultsrcM`. If both are set, the access is a store and `resultsrcM` is ignored.
- **IDLE**
  - With `acc`: capture the request into holding registers (we, addr, wdata, Rd, regwrite) and move to REQ.
  - Without `acc`: pass through to writeback.
- **REQ**
  - `mem_req_o` = 1 and `mem_we_o`/`mem_addr_o`/`mem_wdata_o` are driven from the holding registers. These stay stable until grant.
  - On `mem_gnt_i`, a store returns to IDLE and a load moves to WAIT.
- **WAIT**
  - `mem_req_o` = 0.
  - On `mem_rvalid_i`, write the held load to writeback and return to IDLE.
- `stall_o` = (IDLE & `acc`) | (REQ & ~(`mem_gnt_i` & we)) | (WAIT & ~`mem_rvalid_i`). It deasserts in the completion cycle, so the M registers advance at that edge. This guarantees the same instruction is never retriggered.
- **Writeback register**, updated every cycle:
  - IDLE & ~`acc`: `regwriteW`<=`regwriteM`, `RdW`<=`RdM`, `resultW`<=`aluresultM`.
  - WAIT & `mem_rvalid_i`: `regwriteW`<=held regwrite, `RdW`<=held Rd, `resultW`<=`mem_rdata_i`.
  - All other cycles, including store completion: `regwriteW`<=0 (bubble). `RdW` and `resultW` hold their values.
- `mem_rvalid_i` outside WAIT is ignored. `mem_gnt_i` outside REQ is ignored.

## Timing
- Reset (`arst_n`=0 at an edge) forces:
  - state = IDLE;
  - holding registers = 0;
  - `mem_req_o`/`mem_we_o` = 0 and `mem_addr_o`/`mem_wdata_o` = 0;
  - `regwriteW` = 0, `RdW` = 0, `resultW` = 0;
  - `lsu_err_o` = 0 and the timeout counter = 0.
- `stall_o` is not registered; during and after reset it follows the equation above with state IDLE.
- Reset mid-access drops `mem_req_o` at that edge and abandons any outstanding response.
- ALU op: `resultW` is valid one cycle after the op is present in M.
- Store with immediate grant: detect in cycle 0, `mem_req_o` and grant in cycle 1. `stall_o` is high in cycle 0 only; its minimum total duration is 1 cycle.
- Load with immediate grant and `mem_rvalid_i` one cycle after grant:
  - cycle 0 detect, cycle 1 REQ/grant, cycle 2 WAIT/rvalid;
  - `regwriteW`=1 in cycle 3;
  - `stall_o` is high in cycles 0–1.
- Back-to-back memory ops: the next op is detected in the first cycle after completion, so IDLE lasts ≥1 cycle between requests.

## Configuration
- `LSU_TIMEOUT_EN` defined:
  - A counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When it reaches `TIMEOUT_CYC` without the awaited `mem_gnt_i` or `mem_rvalid_i`, the FSM aborts to IDLE.
  - In the abort cycle, `stall_o` is 0 and `regwriteW`<=0 (the load result is discarded).
  - `lsu_err_o` pulses for exactly one cycle, in the cycle after the abort.
  - Grant or rvalid arriving in the same cycle the count is reached takes priority over the abort.
- Undefined: no counter is present, accesses wait indefinitely, and `lsu_err_o` is tied to 0.

## Test plan
- ALU pass-through: `regwriteM`=1, `RdM`=5, `aluresultM`=0x1234 -> next cycle `regwriteW`=1, `RdW`=5, `resultW`=0x1234, `stall_o` never high.
- Store: `memwriteM`=1, `aluresultM`=0x103, `Rd2M`=0xDEADBEEF, grant after 2 REQ cycles:
  - `mem_addr_o`=0x100 and `mem_we_o`=1, both stable until grant;
  - `stall_o` high for 3 cycles;
  - `regwriteW`=0 throughout.
- Load: `resultsrcM`=1, `RdM`=7, `mem_rdata_i`=0xCAFEF00D with rvalid 3 cycles after grant -> `resultW`=0xCAFEF00D and `RdW`=7 one cycle after rvalid; no other `regwriteW` pulse.
- Reset while in WAIT: assert `arst_n`=0 for 1 cycle, then send an rvalid -> `mem_req_o`=0, no writeback, state IDLE, all outputs at reset values.
- Simultaneous `memwriteM`=`resultsrcM`=1 -> treated as a store (`mem_we_o`=1), no writeback.
- `LSU_TIMEOUT_EN` with `TIMEOUT_CYC`=4 and grant never given -> abort after 4 REQ cycles, one `lsu_err_o` pulse, `regwriteW`=0, and the next instruction proceeds.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit
//   Data-memory responder for the RV32I memory stage. Word loads and stores
//   are issued over a request/grant/response port; the pipeline is stalled
//   while an access is outstanding, and the writeback-stage result register
//   is updated every cycle (ALU results pass through with one cycle latency).
//
//   Optional feature: define LSU_TIMEOUT_EN to enable a watchdog that aborts
//   an access after TIMEOUT_CYC cycles in REQ/WAIT and pulses lsu_err_o.
//
// Ports
//   clk, arst_n                 clock, synchronous active-low reset
//   regwriteM, resultsrcM,
//   memwriteM                   M-stage controls (resultsrcM=1 selects a load)
//   aluresultM                  byte address (memory ops) or ALU result
//   Rd2M                        store data
//   RdM                         destination register
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o     memory request (address word-aligned)
//   mem_gnt_i                   request accepted this cycle
//   mem_rvalid_i, mem_rdata_i   load response
//   stall_o                     combinational pipeline freeze
//   regwriteW, RdW, resultW     writeback-stage register
//   lsu_err_o                   one-cycle watchdog timeout pulse

package rv32i_pkg;
  parameter int DPW = 32;
endpackage

module load_store_unit #(
  parameter int DPW         = rv32i_pkg::DPW,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic           regwriteM,
  input  logic           resultsrcM,
  input  logic           memwriteM,
  input  logic [DPW-1:0] aluresultM,
  input  logic [DPW-1:0] Rd2M,
  input  logic [4:0]     RdM,
  output logic           mem_req_o,
  output logic           mem_we_o,
  output logic [DPW-1:0] mem_addr_o,
  output logic [DPW-1:0] mem_wdata_o,
  input  logic           mem_gnt_i,
  input  logic           mem_rvalid_i,
  input  logic [DPW-1:0] mem_rdata_i,
  output logic           stall_o,
  output logic           regwriteW,
  output logic [4:0]     RdW,
  output logic [DPW-1:0] resultW,
  output logic           lsu_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state, state_next;

  // Request held stable from detection until grant (and, for loads, until
  // the response arrives so the destination is still known).
  logic           hold_we;
  logic [DPW-3:0] hold_addr;
  logic [DPW-1:0] hold_wdata;
  logic [4:0]     hold_rd;
  logic           hold_rw;

  logic acc;
  logic capture;
  logic wb_alu;
  logic wb_load;
  logic timeout_hit;

  assign acc = memwriteM | resultsrcM;

  assign mem_req_o   = (state == REQ);
  assign mem_we_o    = hold_we;
  assign mem_addr_o  = {hold_addr, 2'b00};
  assign mem_wdata_o = hold_wdata;

  // Next state and stall. Stall drops in the completion cycle so the
  // M-stage registers advance exactly once per access.
  always_comb begin
    state_next = state;
    stall_o    = 1'b0;
    capture    = 1'b0;
    wb_alu     = 1'b0;
    wb_load    = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          capture    = 1'b1;
          stall_o    = 1'b1;
          state_next = REQ;
        end else begin
          wb_alu = 1'b1;
        end
      end
      REQ: begin
        if (mem_gnt_i) begin
          state_next = hold_we ? IDLE : WAIT;
          stall_o    = ~hold_we;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
      WAIT: begin
        if (mem_rvalid_i) begin
          wb_load    = 1'b1;
          state_next = IDLE;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state      <= IDLE;
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      hold_rd    <= '0;
      hold_rw    <= 1'b0;
      regwriteW  <= 1'b0;
      RdW        <= '0;
      resultW    <= '0;
    end else begin
      state <= state_next;
      if (capture) begin
        // memwriteM wins when both controls are set: the access is a store.
        hold_we    <= memwriteM;
        hold_addr  <= aluresultM[DPW-1:2];
        hold_wdata <= Rd2M;
        hold_rd    <= RdM;
        hold_rw    <= regwriteM;
      end
      if (wb_alu) begin
        regwriteW <= regwriteM;
        RdW       <= RdM;
        resultW   <= aluresultM;
      end else if (wb_load) begin
        regwriteW <= hold_rw;
        RdW       <= hold_rd;
        resultW   <= mem_rdata_i;
      end else begin
        // Bubble: store completion, stalled cycles, aborts.
        regwriteW <= 1'b0;
      end
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] tmo_cnt;
  logic          abort;

  // The count spans REQ and WAIT together; it saturates at its last value so
  // a grant arriving exactly at the limit leaves no slack for the response.
  assign timeout_hit = (state != IDLE) && (tmo_cnt == TMO_LAST);
  assign abort = timeout_hit &&
                 (((state == REQ) && !mem_gnt_i) || ((state == WAIT) && !mem_rvalid_i));

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      tmo_cnt   <= '0;
      lsu_err_o <= 1'b0;
    end else begin
      if (capture) begin
        tmo_cnt <= '0;
      end else if ((state != IDLE) && (tmo_cnt != TMO_LAST)) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      lsu_err_o <= abort;
    end
  end
`else
  // No watchdog: accesses wait indefinitely. The comparison is never true
  // for a legal limit and only keeps the parameter referenced.
  assign timeout_hit = (TIMEOUT_CYC < 0);
  assign lsu_err_o   = 1'b0;
`endif

endmodule
